// File: rtl/t03_tick_scheduler.sv
// t03_tick_scheduler: one shared prescaler tick multiplexed over N_CH countdown channels.
// Expired channels are presented one at a time on a registered valid/ready done port, round-robin.
//
// state     | meaning
// S_IDLE    | channel free, accepts a load
// S_ARMED   | counting down remaining on each tick
// S_EXPIRED | count reached zero, waiting for the done handshake
module t03_tick_scheduler #(
  parameter int N_CH     = 4,
  parameter int PRESCALE = 5000000,
  parameter int CNT_W    = 16,
  localparam int CH_W    = $clog2(N_CH),
  localparam int PRE_W   = $clog2(PRESCALE)
) (
  input  logic             hwclk,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid,
  input  logic [CH_W-1:0]  req_ch,
  input  logic [CNT_W-1:0] req_ticks,
  output logic             req_ready,
  input  logic             cancel_valid,
  input  logic [CH_W-1:0]  cancel_ch,
  output logic             done_valid,
  output logic [CH_W-1:0]  done_ch,
  input  logic             done_ready,
  output logic [N_CH-1:0]  busy,
  output logic             tick
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EXPIRED} ch_state_e;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  ch_state_e        r_state         [N_CH];
  ch_state_e        w_state_nxt     [N_CH];
  logic [CNT_W-1:0] r_remaining     [N_CH];
  logic [CNT_W-1:0] w_remaining_nxt [N_CH];

  logic [PRE_W-1:0] r_pre_ctr;
  logic             r_tick;
  logic             r_done_valid;
  logic [CH_W-1:0]  r_done_ch;
  logic [CH_W-1:0]  r_rr_ptr;

  logic [N_CH-1:0]  w_cancel_hit;
  logic [N_CH-1:0]  w_expired;
  logic [N_CH-1:0]  w_busy;
  logic             w_accept;
  logic             w_found;
  logic [CH_W-1:0]  w_sel_ch;

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_pre_ctr <= '0;
      r_tick    <= 1'b0;
    end else if (en) begin
      if (r_pre_ctr == PRE_LAST) begin
        r_pre_ctr <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_pre_ctr <= r_pre_ctr + PRE_W'(1);
        r_tick    <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign w_accept = r_done_valid && done_ready;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_state_nxt[i]     = r_state[i];
      w_remaining_nxt[i] = r_remaining[i];
      // A cancel aimed at the channel currently on the done port is dropped.
      w_cancel_hit[i] = cancel_valid && (cancel_ch == CH_W'(i)) && (r_state[i] != S_IDLE)
                        && !(r_done_valid && (r_done_ch == CH_W'(i)));
      w_expired[i]    = (r_state[i] == S_EXPIRED) && !w_cancel_hit[i];
      w_busy[i]       = (r_state[i] != S_IDLE);
      case (r_state[i])
        S_IDLE: begin
          if (req_valid && (req_ch == CH_W'(i))) begin
            w_remaining_nxt[i] = req_ticks;
            w_state_nxt[i]     = (req_ticks == '0) ? S_EXPIRED : S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_cancel_hit[i]) begin
            w_state_nxt[i]     = S_IDLE;
            w_remaining_nxt[i] = '0;
          end else if (r_tick) begin
            if (r_remaining[i] <= CNT_W'(1)) begin
              w_state_nxt[i]     = S_EXPIRED;
              w_remaining_nxt[i] = '0;
            end else begin
              w_remaining_nxt[i] = r_remaining[i] - CNT_W'(1);
            end
          end
        end
        S_EXPIRED: begin
          if ((w_accept && (r_done_ch == CH_W'(i))) || w_cancel_hit[i]) begin
            w_state_nxt[i]     = S_IDLE;
            w_remaining_nxt[i] = '0;
          end
        end
        default: begin
          w_state_nxt[i]     = S_IDLE;
          w_remaining_nxt[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i]     <= S_IDLE;
        r_remaining[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i]     <= w_state_nxt[i];
        r_remaining[i] <= w_remaining_nxt[i];
      end
    end
  end

  // Round-robin search; the pointer add wraps because N_CH is a power of two.
  always_comb begin
    w_found  = 1'b0;
    w_sel_ch = r_rr_ptr;
    for (int k = 0; k < N_CH; k++) begin
      if (!w_found && w_expired[r_rr_ptr + CH_W'(k)]) begin
        w_found  = 1'b1;
        w_sel_ch = r_rr_ptr + CH_W'(k);
      end
    end
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_done_valid <= 1'b0;
      r_done_ch    <= '0;
      r_rr_ptr     <= '0;
    end else if (r_done_valid) begin
      if (done_ready) begin
        r_done_valid <= 1'b0;
        r_rr_ptr     <= r_done_ch + CH_W'(1);
      end
    end else if (w_found) begin
      r_done_valid <= 1'b1;
      r_done_ch    <= w_sel_ch;
    end
  end

  assign req_ready  = (r_state[req_ch] == S_IDLE);
  assign done_valid = r_done_valid;
  assign done_ch    = r_done_ch;
  assign busy       = w_busy;
  assign tick       = r_tick;

endmodule

// File: tb/tb_t03_tick_scheduler.sv
// Bench for t03_tick_scheduler: directed scenarios plus randomized traffic
// checked against a tick-count reference model of the scheduler.
module tb_t03_tick_scheduler;
  localparam int N   = 4;
  localparam int PRE = 4;

  logic        hwclk = 1'b0;
  logic        rst, en, req_valid, req_ready, cancel_valid, done_valid, done_ready, tick;
  logic [1:0]  req_ch, cancel_ch, done_ch;
  logic [15:0] req_ticks;
  logic [3:0]  busy;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: enabled-edge count since reset, per-channel activity and ticks left
  int m_cnt;
  bit m_tick;
  bit m_act  [N];
  int m_left [N];
  bit m_dv;
  int m_dch;
  int m_rr;

  t03_tick_scheduler #(.N_CH(N), .PRESCALE(PRE), .CNT_W(16)) dut (
    .hwclk(hwclk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ch(req_ch), .req_ticks(req_ticks), .req_ready(req_ready),
    .cancel_valid(cancel_valid), .cancel_ch(cancel_ch),
    .done_valid(done_valid), .done_ch(done_ch), .done_ready(done_ready),
    .busy(busy), .tick(tick)
  );

  always #5 hwclk = ~hwclk;

  function automatic logic [3:0] exp_busy();
    logic [3:0] b;
    for (int i = 0; i < N; i++) b[i] = m_act[i];
    return b;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_dv = 0; m_dch = 0; m_rr = 0;
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_left[i] = 0; end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_ch = '0; req_ticks = '0;
    cancel_valid = 1'b0; cancel_ch = '0; done_ready = 1'b0;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  // advance one clock; the model consumes the inputs present before the edge
  task automatic step();
    bit n_act [N];
    int n_left [N];
    bit canc [N];
    bit acc, found, n_dv, n_tick;
    int n_dch, n_rr, n_cnt, j;
    n_cnt = m_cnt; n_tick = 0;
    if (en) begin n_cnt = m_cnt + 1; n_tick = (n_cnt % PRE == 0); end
    acc = m_dv && done_ready;
    for (int i = 0; i < N; i++) begin
      canc[i]   = cancel_valid && (cancel_ch == i) && m_act[i] && !(m_dv && m_dch == i);
      n_act[i]  = m_act[i];
      n_left[i] = m_left[i];
      if (req_valid && req_ch == i && !m_act[i]) begin
        n_act[i] = 1; n_left[i] = req_ticks;
      end else if (acc && m_dch == i) n_act[i] = 0;
      else if (canc[i]) n_act[i] = 0;
      else if (m_act[i] && m_left[i] > 0 && m_tick) n_left[i] = m_left[i] - 1;
    end
    n_dv = m_dv; n_dch = m_dch; n_rr = m_rr;
    if (m_dv) begin
      if (acc) begin n_dv = 0; n_rr = (m_dch + 1) % N; end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!found && m_act[j] && m_left[j] == 0 && !canc[j]) begin
          found = 1; n_dv = 1; n_dch = j;
        end
      end
    end
    @(posedge hwclk);
    #1;
    m_cnt = n_cnt; m_tick = n_tick; m_dv = n_dv; m_dch = n_dch; m_rr = n_rr;
    for (int i = 0; i < N; i++) begin m_act[i] = n_act[i]; m_left[i] = n_left[i]; end
  endtask

  task automatic arm(input int ch, input int ticks);
    req_valid = 1'b1; req_ch = 2'(ch); req_ticks = 16'(ticks);
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req_valid = 1'b0; req_ch = '0; req_ticks = '0;
    cancel_valid = 1'b0; cancel_ch = '0; done_ready = 1'b0;
    #1;
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b want 0", tick); end
    n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", busy); end
    n_checks++; if (done_valid !== 1'b0 || done_ch !== 2'd0) begin
      n_fail++; $display("FAIL reset_done: got valid=%0b ch=%0d want 0/0", done_valid, done_ch);
    end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_prescaler();
    int nt, first;
    do_reset();
    en = 1'b1; nt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (tick === 1'b1) nt++;
      n_checks++; if (tick !== m_tick) begin n_fail++; $display("FAIL prescale_tick c%0d: got %0b want %0b", c, tick, m_tick); end
    end
    n_checks++; if (nt != 3) begin n_fail++; $display("FAIL prescale_count: got %0d want 3", nt); end
    en = 1'b0; nt = 0;
    for (int c = 0; c < 6; c++) begin step(); if (tick !== 1'b0) nt++; end
    n_checks++; if (nt != 0) begin n_fail++; $display("FAIL en_low_ticks: got %0d want 0", nt); end
    en = 1'b1; first = -1;
    for (int c = 1; c <= 8 && first < 0; c++) begin step(); if (tick === 1'b1) first = c; end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL prescale_frozen: first tick after %0d edges want 4", first); end
    n_checks++; if (busy !== 4'b0 || done_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_outputs: busy=%b done_valid=%0b want 0000/0", busy, done_valid);
    end
  endtask

  task automatic test_single();
    int seen, third_at, pulses, gap;
    do_reset();
    en = 1'b1; done_ready = 1'b1;
    req_ch = 2'd2; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL single_req_ready: got %0b want 1", req_ready); end
    arm(2, 3);
    n_checks++; if (busy !== 4'b0100) begin n_fail++; $display("FAIL single_busy: got %b want 0100", busy); end
    seen = 0; third_at = -1; pulses = 0; gap = -1;
    for (int c = 0; c < 30; c++) begin
      if (tick === 1'b1) begin seen++; if (seen == 3) third_at = c; end
      if (done_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) gap = c - third_at;
        n_checks++; if (done_ch !== 2'd2) begin n_fail++; $display("FAIL single_done_ch: got %0d want 2", done_ch); end
      end
      step();
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    n_checks++; if (gap != 2) begin n_fail++; $display("FAIL single_latency: got %0d samples after 3rd tick want 2", gap); end
    n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0000", busy); end
  endtask

  task automatic test_rr_stall();
    int order[$];
    int guard, unstable;
    do_reset();
    en = 1'b1; done_ready = 1'b0; guard = 0;
    while (tick !== 1'b1 && guard < 10) begin step(); guard++; end
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL rr_tick_wait: got %0b want 1", tick); end
    arm(0, 1); arm(1, 1); arm(3, 1);
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done_valid === 1'b1 && done_ch !== 2'd0) unstable++;
    end
    n_checks++; if (done_valid !== 1'b1 || done_ch !== 2'd0 || unstable != 0) begin
      n_fail++; $display("FAIL rr_stall: got valid=%0b ch=%0d unstable=%0d want 1/0/0", done_valid, done_ch, unstable);
    end
    done_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done_valid === 1'b1) order.push_back(int'(done_ch));
      step();
    end
    n_checks++; if (order.size() != 3) begin n_fail++; $display("FAIL rr_count: got %0d accepts want 3", order.size()); end
    else begin
      n_checks++; if (order[0] != 0 || order[1] != 1 || order[2] != 3) begin
        n_fail++; $display("FAIL rr_order: got %0d,%0d,%0d want 0,1,3", order[0], order[1], order[2]);
      end
    end
  endtask

  task automatic test_zero_ticks();
    do_reset();
    en = 1'b1; done_ready = 1'b0;
    arm(1, 0);
    for (int c = 0; c < 2 && done_valid !== 1'b1; c++) step();
    n_checks++; if (done_valid !== 1'b1 || done_ch !== 2'd1) begin
      n_fail++; $display("FAIL zero_done: got valid=%0b ch=%0d want 1/1", done_valid, done_ch);
    end
    req_valid = 1'b1; req_ch = 2'd1; req_ticks = 16'd7; #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL zero_req_ready: got %0b want 0", req_ready); end
    step();
    req_valid = 1'b0;
    n_checks++; if (busy !== 4'b0010 || done_valid !== 1'b1 || done_ch !== 2'd1) begin
      n_fail++; $display("FAIL zero_hold: busy=%b valid=%0b ch=%0d want 0010/1/1", busy, done_valid, done_ch);
    end
    done_ready = 1'b1;
    step();
    n_checks++; if (busy !== 4'b0 || done_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_accept: busy=%b valid=%0b want 0000/0", busy, done_valid);
    end
  endtask

  task automatic test_cancel();
    int seen, guard, dv_cnt;
    do_reset();
    en = 1'b1; done_ready = 1'b1;
    arm(2, 5);
    seen = 0; guard = 0;
    while (seen < 2 && guard < 20) begin step(); guard++; if (tick === 1'b1) seen++; end
    step();
    cancel_valid = 1'b1; cancel_ch = 2'd2;
    step();
    cancel_valid = 1'b0;
    n_checks++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %0b want 0", busy[2]); end
    dv_cnt = 0;
    for (int c = 0; c < 30; c++) begin step(); if (done_valid !== 1'b0) dv_cnt++; end
    n_checks++; if (dv_cnt != 0) begin n_fail++; $display("FAIL cancel_no_done: got %0d want 0", dv_cnt); end
    arm(2, 5);
    guard = 0;
    while (tick !== 1'b1 && guard < 10) begin step(); guard++; end
    cancel_valid = 1'b1; cancel_ch = 2'd2;
    step();
    cancel_valid = 1'b0;
    dv_cnt = 0;
    for (int c = 0; c < 30; c++) begin step(); if (done_valid !== 1'b0) dv_cnt++; end
    n_checks++; if (busy[2] !== 1'b0 || dv_cnt != 0) begin
      n_fail++; $display("FAIL cancel_on_tick: busy2=%0b dones=%0d want 0/0", busy[2], dv_cnt);
    end
    cancel_valid = 1'b1; cancel_ch = 2'd0;
    arm(0, 2);
    cancel_valid = 1'b0;
    n_checks++; if (busy !== 4'b0001) begin n_fail++; $display("FAIL load_beats_cancel: got %b want 0001", busy); end
  endtask

  task automatic test_async_reset();
    int guard, bad;
    do_reset();
    en = 1'b1; done_ready = 1'b0;
    arm(0, 100);
    arm(3, 0);
    guard = 0;
    while (done_valid !== 1'b1 && guard < 5) begin step(); guard++; end
    n_checks++; if (done_valid !== 1'b1 || done_ch !== 2'd3 || busy !== 4'b1001) begin
      n_fail++; $display("FAIL pre_rst: valid=%0b ch=%0d busy=%b want 1/3/1001", done_valid, done_ch, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 4'b0 || done_valid !== 1'b0 || done_ch !== 2'd0 || tick !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: busy=%b valid=%0b ch=%0d tick=%0b want all 0", busy, done_valid, done_ch, tick);
    end
    #2;
    rst = 1'b0;
    model_reset();
    done_ready = 1'b1; bad = 0;
    for (int c = 0; c < 40; c++) begin step(); if (done_valid !== 1'b0 || busy !== 4'b0) bad++; end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL post_rst_quiet: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en           = ($urandom_range(0, 9) != 0);
      req_valid    = ($urandom_range(0, 2) == 0);
      req_ch       = 2'($urandom_range(0, 3));
      req_ticks    = 16'($urandom_range(0, 5));
      cancel_valid = ($urandom_range(0, 7) == 0);
      cancel_ch    = 2'($urandom_range(0, 3));
      done_ready   = ($urandom_range(0, 1) == 1);
      #1;
      n_checks++; if (req_ready !== !m_act[req_ch]) begin
        n_fail++; $display("FAIL rnd_req_ready c%0d: got %0b want %0b", c, req_ready, !m_act[req_ch]);
      end
      step();
      n_checks++; if (tick !== m_tick) begin n_fail++; $display("FAIL rnd_tick c%0d: got %0b want %0b", c, tick, m_tick); end
      n_checks++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, exp_busy()); end
      n_checks++; if (done_valid !== m_dv) begin n_fail++; $display("FAIL rnd_done_valid c%0d: got %0b want %0b", c, done_valid, m_dv); end
      if (m_dv) begin
        n_checks++; if (done_ch !== 2'(m_dch)) begin n_fail++; $display("FAIL rnd_done_ch c%0d: got %0d want %0d", c, done_ch, m_dch); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_single();
    test_rr_stall();
    test_zero_ticks();
    test_cancel();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
